mc_req_arb: RTL

- Shares one MC request/response port among NUM_REQ vadd function pipes.
- Each requester gets a 4-entry skid FIFO. A round-robin arbiter picks one request per cycle. Loads are tagged with the requester ID in rdctl.
- Read responses are steered back to the owning requester by that tag.
- Sits between the vadd instances and the MC interface in the personality top.

---
 rtl/mc_req_arb_pkg.sv | 23 ++
 rtl/mc_arb_req_fifo.sv | 63 ++++++
 rtl/mc_req_arb.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mc_req_arb_pkg.sv
// Shared types and constants for the MC request arbiter: queued entry layout,
// request size encoding and the rdctl requester-ID mask helper.
package mc_req_arb_pkg;

    localparam int VADR_W      = 48;
    localparam int DATA_W      = 64;
    localparam int RSP_RDCTL_W = 32;

    localparam logic [1:0] REQ_SIZE_8B = 2'h3;

    typedef struct packed {
        logic              st;
        logic [VADR_W-1:0] vadr;
        logic [DATA_W-1:0] data;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    function automatic logic [DATA_W-1:0] tag_mask(input int lsb, input int w);
        return ((64'd1 << w) - 64'd1) << lsb;
    endfunction

endpackage

// File: rtl/mc_arb_req_fifo.sv
// Per-requester skid FIFO: synchronous, first-word-fall-through read port.
// Pushes into a full FIFO and pops from an empty one are ignored.
module mc_arb_req_fifo #(
    parameter int WIDTH = 113,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mc_req_arb.sv
// Shares one MC request/response port among NUM_REQ requesters with round-robin
// issue and rdctl ID tagging. Optional stats counters: MC_REQ_ARB_STATS_EN.
module mc_req_arb
    import mc_req_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 3,
    parameter int TAG_LSB    = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AFULL = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      rq_ld,
    input  logic [NUM_REQ-1:0]      rq_st,
    input  logic [NUM_REQ*48-1:0]   rq_vadr,
    input  logic [NUM_REQ*64-1:0]   rq_wrd_rdctl,
    output logic [NUM_REQ-1:0]      rq_rd_stall,
    output logic [NUM_REQ-1:0]      rq_wr_stall,
    output logic                    mc_req_ld,
    output logic                    mc_req_st,
    output logic [47:0]             mc_req_vadr,
    output logic [1:0]              mc_req_size,
    output logic                    mc_req_flush,
    output logic [63:0]             mc_req_wrd_rdctl,
    input  logic                    mc_rd_rq_stall,
    input  logic                    mc_wr_rq_stall,
    input  logic                    mc_rsp_push,
    input  logic [31:0]             mc_rsp_rdctl,
    input  logic [63:0]             mc_rsp_data,
    output logic                    mc_rsp_stall,
    output logic [NUM_REQ-1:0]      rsp_push,
    output logic [31:0]             rsp_rdctl,
    output logic [63:0]             rsp_data,
    input  logic [NUM_REQ-1:0]      rsp_stall,
    output logic                    arb_err
`ifdef MC_REQ_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]   arb_gnt_cnt,
    output logic [31:0]             arb_stall_cyc
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [DATA_W-1:0] TAG_MASK = tag_mask(TAG_LSB, ID_W);

    req_entry_t          fifo_din  [NUM_REQ];
    req_entry_t          fifo_dout [NUM_REQ];
    logic [CNT_W-1:0]    fifo_cnt  [NUM_REQ];
    logic [NUM_REQ-1:0]  fifo_push;
    logic [NUM_REQ-1:0]  fifo_pop;
    logic [NUM_REQ-1:0]  fifo_empty;
    logic [NUM_REQ-1:0]  fifo_full;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  stall_nxt;
    logic [NUM_REQ-1:0]  rsp_dec;

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_vld;
    req_entry_t          gnt_entry;
    logic [DATA_W-1:0]   gnt_tagged;
    logic [ID_W-1:0]     rsp_tag;
    logic                rsp_tag_ok;
    logic                cap_err;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
            assign fifo_push[i] = (rq_ld[i] | rq_st[i]) & ~fifo_full[i];
            // A simultaneous load+store keeps the store; the load is lost.
            assign fifo_din[i]  = '{st:   rq_st[i],
                                    vadr: rq_vadr[48*i +: 48],
                                    data: rq_wrd_rdctl[64*i +: 64]};
            assign elig[i]      = ~fifo_empty[i] &
                                  (fifo_dout[i].st ? ~mc_wr_rq_stall : ~mc_rd_rq_stall);
            assign fifo_pop[i]  = gnt_vld & (gnt_idx == ID_W'(i));
            assign stall_nxt[i] = (32'(fifo_cnt[i]) >= FIFO_AFULL);

            mc_arb_req_fifo #(
                .WIDTH (ENTRY_W),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (fifo_push[i]),
                .pop   (fifo_pop[i]),
                .din   (fifo_din[i]),
                .dout  (fifo_dout[i]),
                .empty (fifo_empty[i]),
                .full  (fifo_full[i]),
                .cnt   (fifo_cnt[i])
            );
        end
    endgenerate

    // First eligible head at or after the round-robin pointer.
    always_comb begin
        int cand;
        cand    = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(cand);
            end
        end
    end

    always_comb begin
        gnt_entry = fifo_dout[0];
        for (int i = 1; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                gnt_entry = fifo_dout[i];
            end
        end
    end

    assign gnt_tagged = (gnt_entry.data & ~TAG_MASK) | (DATA_W'(gnt_idx) << TAG_LSB);

    always_comb begin
        rsp_tag    = mc_rsp_rdctl[TAG_LSB +: ID_W];
        rsp_tag_ok = (32'(rsp_tag) < NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_dec[i] = mc_rsp_push & (rsp_tag == ID_W'(i));
        end
    end

    assign cap_err      = |(rq_ld & rq_st) | |((rq_ld | rq_st) & fifo_full);
    assign mc_req_size  = REQ_SIZE_8B;
    assign mc_req_flush = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr           <= '0;
            mc_req_ld        <= 1'b0;
            mc_req_st        <= 1'b0;
            mc_req_vadr      <= '0;
            mc_req_wrd_rdctl <= '0;
            rq_rd_stall      <= '0;
            rq_wr_stall      <= '0;
            rsp_push         <= '0;
            rsp_rdctl        <= '0;
            rsp_data         <= '0;
            mc_rsp_stall     <= 1'b0;
            arb_err          <= 1'b0;
        end else begin
            mc_req_ld <= gnt_vld & ~gnt_entry.st;
            mc_req_st <= gnt_vld & gnt_entry.st;
            if (gnt_vld) begin
                mc_req_vadr      <= gnt_entry.vadr;
                mc_req_wrd_rdctl <= gnt_entry.st ? gnt_entry.data : gnt_tagged;
                rr_ptr           <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end

            rq_rd_stall <= stall_nxt;
            rq_wr_stall <= stall_nxt;

            rsp_push <= rsp_dec;
            if (mc_rsp_push && rsp_tag_ok) begin
                rsp_rdctl <= mc_rsp_rdctl & ~TAG_MASK[RSP_RDCTL_W-1:0];
                rsp_data  <= mc_rsp_data;
            end
            mc_rsp_stall <= |rsp_stall;

            if (cap_err || (mc_rsp_push && !rsp_tag_ok)) begin
                arb_err <= 1'b1;
            end
        end
    end

`ifdef MC_REQ_ARB_STATS_EN
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
            always_ff @(posedge clk) begin
                if (reset) begin
                    arb_gnt_cnt[32*i +: 32] <= '0;
                end else if (fifo_pop[i] && (arb_gnt_cnt[32*i +: 32] != '1)) begin
                    arb_gnt_cnt[32*i +: 32] <= arb_gnt_cnt[32*i +: 32] + 32'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            arb_stall_cyc <= '0;
        end else if ((~&fifo_empty) && !gnt_vld && (arb_stall_cyc != '1)) begin
            arb_stall_cyc <= arb_stall_cyc + 32'd1;
        end
    end
`endif

endmodule
